// File: rtl/alu_pkg.sv
// Shared types for the sequenced ALU: opcode encoding, flag bit positions
// and FSM state encoding.
package alu_pkg;

    // Codes 0-7 keep the legacy 3-bit ALU encoding unchanged.
    typedef enum logic [3:0] {
        OP_OR    = 4'd0,
        OP_AND   = 4'd1,
        OP_XOR   = 4'd2,
        OP_NAND  = 4'd3,
        OP_PASSB = 4'd4,
        OP_INC   = 4'd5,
        OP_ADD   = 4'd6,
        OP_SUB   = 4'd7,
        OP_SLL   = 4'd8,
        OP_SRL   = 4'd9,
        OP_SRA   = 4'd10,
        OP_SLT   = 4'd11,
        OP_MUL   = 4'd12,
        OP_MULHU = 4'd13,
        OP_RSV14 = 4'd14,
        OP_RSV15 = 4'd15
    } opcode_e;

    // Positions inside the 4-bit {N,Z,C,V} flag vector.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    // True for the opcodes that go through the iterative multiplier.
    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU);
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier. One partial product per cycle,
// WIDTH cycles per multiply; done pulses for one cycle with prod valid.
module alu_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 done,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   prod
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [CW-1:0]      r_cnt;
    logic               r_run;
    logic               r_done;
    logic [WIDTH:0]     w_add;

    // Multiplier stays in the low half and is consumed one bit per step;
    // the upper half accumulates with a carry bit that shifts back in.
    assign w_add = r_prod[0] ? ({1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand})
                             :  {1'b0, r_prod[2*WIDTH-1:WIDTH]};

    // Load on start, then WIDTH add-and-shift iterations counted 0..WIDTH-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand <= '0;
            r_prod  <= '0;
            r_cnt   <= '0;
            r_run   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_mcand <= A;
                r_prod  <= {{WIDTH{1'b0}}, B};
                r_cnt   <= '0;
                r_run   <= 1'b1;
            end else if (r_run) begin
                r_prod <= {w_add, r_prod[WIDTH-1:1]};
                if (r_cnt == CW'(WIDTH-1)) begin
                    r_cnt  <= '0;
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign done = r_done;
    assign busy = r_run;
    assign prod = r_prod;

endmodule

// File: rtl/alu_seq.sv
// Single-issue ALU execution unit with valid/ready on both sides.
// Single-cycle ops resolve combinationally and land in the output
// registers one edge after accept; MUL/MULHU run through alu_mul_seq.
//
//   state | meaning
//   IDLE  | no result held, ready for a new operation
//   MUL   | multiply in flight, input side stalled
//   DONE  | result valid on z/flags, held until out_ready
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic [3:0]       flags,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    state_e             r_state;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_z;
    logic [3:0]         r_flags;
    logic               r_mul_hi;

    logic               w_accept;
    logic               w_is_mul;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_inc;
    logic [WIDTH:0]     w_diff;
    logic [SHW-1:0]     w_shamt;
    logic               w_lt;
    logic [WIDTH-1:0]   w_alu_z;
    logic               w_alu_c;
    logic               w_alu_v;
    logic [3:0]         w_alu_flags;
    logic               w_mul_done;
    logic               w_mul_busy;
    logic [2*WIDTH-1:0] w_mul_prod;
    logic [WIDTH-1:0]   w_mul_z;
    logic [3:0]         w_mul_flags;

    // Ready never looks at in_valid, so upstream can use it without a loop.
    assign in_ready = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_is_mul = is_mul_op(opcode);

    assign w_sum   = {1'b0, A} + {1'b0, B};
    assign w_inc   = {1'b0, A} + {{WIDTH{1'b0}}, 1'b1};
    assign w_diff  = {1'b0, A} - {1'b0, B};
    assign w_shamt = B[SHW-1:0];
    assign w_lt    = $signed(A) < $signed(B);

    // Single-cycle datapath; carry/overflow only meaningful for INC/ADD/SUB.
    always_comb begin
        w_alu_z = '0;
        w_alu_c = 1'b0;
        w_alu_v = 1'b0;
        case (opcode)
            OP_OR:    w_alu_z = A | B;
            OP_AND:   w_alu_z = A & B;
            OP_XOR:   w_alu_z = A ^ B;
            OP_NAND:  w_alu_z = ~(A & B);
            OP_PASSB: w_alu_z = B;
            OP_INC: begin
                w_alu_z = w_inc[WIDTH-1:0];
                w_alu_c = w_inc[WIDTH];
                w_alu_v = ~A[MSB] & w_inc[MSB];
            end
            OP_ADD: begin
                w_alu_z = w_sum[WIDTH-1:0];
                w_alu_c = w_sum[WIDTH];
                w_alu_v = (A[MSB] == B[MSB]) && (w_sum[MSB] != A[MSB]);
            end
            OP_SUB: begin
                // Top bit of the widened difference is the unsigned borrow.
                w_alu_z = w_diff[WIDTH-1:0];
                w_alu_c = w_diff[WIDTH];
                w_alu_v = (A[MSB] != B[MSB]) && (w_diff[MSB] != A[MSB]);
            end
            OP_SLL:   w_alu_z = A << w_shamt;
            OP_SRL:   w_alu_z = A >> w_shamt;
            OP_SRA:   w_alu_z = $signed(A) >>> w_shamt;
            OP_SLT:   w_alu_z = {{(WIDTH-1){1'b0}}, w_lt};
            default:  w_alu_z = '0;
        endcase
    end

    // Flag vector for single-cycle results; reserved ops fall out as Z only.
    always_comb begin
        w_alu_flags         = '0;
        w_alu_flags[FLAG_N] = w_alu_z[MSB];
        w_alu_flags[FLAG_Z] = (w_alu_z == '0);
        w_alu_flags[FLAG_C] = w_alu_c;
        w_alu_flags[FLAG_V] = w_alu_v;
    end

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_accept && w_is_mul),
        .A     (A),
        .B     (B),
        .done  (w_mul_done),
        .busy  (w_mul_busy),
        .prod  (w_mul_prod)
    );

    assign w_mul_z = r_mul_hi ? w_mul_prod[2*WIDTH-1:WIDTH] : w_mul_prod[WIDTH-1:0];

    // Multiply results carry only N and Z.
    always_comb begin
        w_mul_flags         = '0;
        w_mul_flags[FLAG_N] = w_mul_z[MSB];
        w_mul_flags[FLAG_Z] = (w_mul_z == '0);
    end

    // Control FSM and output registers; z/flags move only when a result lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_z         <= '0;
            r_flags     <= '0;
            r_mul_hi    <= 1'b0;
        end else if (w_accept) begin
            if (w_is_mul) begin
                r_state     <= MUL;
                r_out_valid <= 1'b0;
                r_mul_hi    <= (opcode == OP_MULHU);
            end else begin
                r_state     <= DONE;
                r_out_valid <= 1'b1;
                r_z         <= w_alu_z;
                r_flags     <= w_alu_flags;
            end
        end else begin
            case (r_state)
                MUL: begin
                    if (w_mul_done) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_z         <= w_mul_z;
                        r_flags     <= w_mul_flags;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign z         = r_z;
    assign flags     = r_flags;
    assign busy      = w_mul_busy;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH = 16). Inputs change and outputs are
// sampled 1 ns after the rising edge.
module tb_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic [3:0]  opcode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] z;
    logic [3:0]  flags;
    logic        busy;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] ez;
        logic [3:0]  ef;
    } vec_t;

    vec_t vecs [19];

    alu_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .flags     (flags),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Presents one operation; returns 1 ns after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        opcode   = op;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        opcode    = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (z !== 16'h0000) begin errors++; $display("FAIL reset_z: got %h want 0000", z); end
        checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", flags); end
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_ops;
        vecs = '{
            '{4'd0,  16'h0F0F, 16'h00FF, 16'h0FFF, 4'b0000},
            '{4'd1,  16'h0F0F, 16'h00FF, 16'h000F, 4'b0000},
            '{4'd2,  16'h0F0F, 16'h00FF, 16'h0FF0, 4'b0000},
            '{4'd3,  16'hFFFF, 16'h00FF, 16'hFF00, 4'b1000},
            '{4'd4,  16'h1234, 16'h8001, 16'h8001, 4'b1000},
            '{4'd5,  16'hFFFF, 16'h0000, 16'h0000, 4'b0110},
            '{4'd5,  16'h7FFF, 16'h0000, 16'h8000, 4'b1001},
            '{4'd6,  16'h7FFF, 16'h0001, 16'h8000, 4'b1001},
            '{4'd6,  16'h8000, 16'h8000, 16'h0000, 4'b0111},
            '{4'd7,  16'h0000, 16'h0001, 16'hFFFF, 4'b1010},
            '{4'd7,  16'h8000, 16'h0001, 16'h7FFF, 4'b0001},
            '{4'd7,  16'h0005, 16'h0005, 16'h0000, 4'b0100},
            '{4'd8,  16'h0001, 16'h0024, 16'h0010, 4'b0000},
            '{4'd9,  16'h8000, 16'h000F, 16'h0001, 4'b0000},
            '{4'd10, 16'h8000, 16'h0013, 16'hF000, 4'b1000},
            '{4'd11, 16'hFFFF, 16'h0001, 16'h0001, 4'b0000},
            '{4'd11, 16'h0001, 16'hFFFF, 16'h0000, 4'b0100},
            '{4'd14, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0100},
            '{4'd15, 16'h1234, 16'h5678, 16'h0000, 4'b0100}
        };
        out_ready = 1'b1;
        for (int i = 0; i < 19; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL op%0d_vec%0d_out_valid: got %0b want 1", vecs[i].op, i, out_valid); end
            checks++; if (z !== vecs[i].ez) begin errors++; $display("FAIL op%0d_vec%0d_z: got %h want %h", vecs[i].op, i, z, vecs[i].ez); end
            checks++; if (flags !== vecs[i].ef) begin errors++; $display("FAIL op%0d_vec%0d_flags: got %b want %b", vecs[i].op, i, flags, vecs[i].ef); end
        end
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_idle_out_valid: got %0b want 0", out_valid); end
        checks++; if (z !== 16'h0000) begin errors++; $display("FAIL single_idle_z_hold: got %h want 0000", z); end
    endtask

    task automatic test_mul(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] ez, input logic [3:0] ef);
        int  k;
        int  busy_cnt;
        int  ready_hi;
        bit  seen;
        out_ready = 1'b1;
        issue(op, a, b);
        A = 16'h5A5A;
        B = 16'hA5A5;
        k = 0; busy_cnt = 0; ready_hi = 0; seen = 1'b0;
        while (!seen && k < 40) begin
            if (out_valid === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (busy === 1'b1) busy_cnt++;
                if (in_ready !== 1'b0) ready_hi++;
                @(posedge clk);
                #1;
                k++;
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL mul_op%0d_timeout: no out_valid after %0d cycles", op, k); end
        checks++; if (k != 17) begin errors++; $display("FAIL mul_op%0d_latency: got %0d want 17", op, k); end
        checks++; if (busy_cnt != 16) begin errors++; $display("FAIL mul_op%0d_busy_cycles: got %0d want 16", op, busy_cnt); end
        checks++; if (ready_hi != 0) begin errors++; $display("FAIL mul_op%0d_in_ready_while_busy: got %0d high cycles want 0", op, ready_hi); end
        checks++; if (z !== ez) begin errors++; $display("FAIL mul_op%0d_z: got %h want %h", op, z, ez); end
        checks++; if (flags !== ef) begin errors++; $display("FAIL mul_op%0d_flags: got %b want %b", op, flags, ef); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        issue(4'd6, 16'h7FFF, 16'h0001);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %0b want 1", out_valid); end
        opcode   = 4'd2;
        A        = 16'h00FF;
        B        = 16'h0F0F;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (z !== 16'h8000) begin errors++; $display("FAIL bp_z_hold_%0d: got %h want 8000", i, z); end
            checks++; if (flags !== 4'b1001) begin errors++; $display("FAIL bp_flags_hold_%0d: got %b want 1001", i, flags); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_%0d: got %0b want 0", i, in_ready); end
            @(posedge clk);
            #1;
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid_held: got %0b want 1", out_valid); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %0b want 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_xor_out_valid: got %0b want 1", out_valid); end
        checks++; if (z !== 16'h0FF0) begin errors++; $display("FAIL bp_xor_z: got %h want 0ff0", z); end
        checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL bp_xor_flags: got %b want 0000", flags); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        issue(4'd6, 16'h0001, 16'h0002);
        checks++; if (out_valid !== 1'b1 || z !== 16'h0003) begin errors++; $display("FAIL b2b_first: got valid=%0b z=%h want valid=1 z=0003", out_valid, z); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %0b want 1", in_ready); end
        issue(4'd7, 16'h000A, 16'h0003);
        checks++; if (out_valid !== 1'b1 || z !== 16'h0007) begin errors++; $display("FAIL b2b_second: got valid=%0b z=%h want valid=1 z=0007", out_valid, z); end
        issue(4'd0, 16'h00F0, 16'h0F00);
        checks++; if (out_valid !== 1'b1 || z !== 16'h0FF0) begin errors++; $display("FAIL b2b_third: got valid=%0b z=%h want valid=1 z=0ff0", out_valid, z); end
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %0b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_mul;
        int stray;
        out_ready = 1'b1;
        issue(4'd12, 16'h0123, 16'h0010);
        repeat (8) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmul_busy_before: got %0b want 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmul_out_valid: got %0b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmul_busy: got %0b want 0", busy); end
        checks++; if (z !== 16'h0000) begin errors++; $display("FAIL rmul_z: got %h want 0000", z); end
        checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL rmul_flags: got %b want 0000", flags); end
        #2;
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmul_in_ready: got %0b want 1", in_ready); end
        @(posedge clk);
        #1;
        issue(4'd6, 16'h0002, 16'h0003);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmul_add_latency: got valid=%0b want 1", out_valid); end
        checks++; if (z !== 16'h0005) begin errors++; $display("FAIL rmul_add_z: got %h want 0005", z); end
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1 || busy === 1'b1) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL rmul_no_stray_result: got %0d active cycles want 0", stray); end
        checks++; if (z !== 16'h0005) begin errors++; $display("FAIL rmul_z_hold: got %h want 0005", z); end
    endtask

    initial begin
        test_reset();
        test_single_ops();
        test_mul(4'd12, 16'h0123, 16'h0010, 16'h1230, 4'b0000);
        test_mul(4'd13, 16'hFFFF, 16'hFFFF, 16'hFFFE, 4'b1000);
        test_mul(4'd12, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0000);
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
